// File: rtl/mastermind_pkg.sv
// Shared definitions for the Mastermind game controller: board geometry,
// colour codes, FSM state encoding and a secret/row validity helper.
// Optional feature macro used by the controller: MASTERMIND_FEEDBACK_EN.
package mastermind_pkg;

    localparam int COLS      = 4;
    localparam int ROWS      = 6;
    localparam int SLOT_BITS = 3;
    localparam int ROW_BITS  = COLS * SLOT_BITS;
    localparam int FB_BITS   = 2 * SLOT_BITS;

    localparam logic [2:0] COLOR_EMPTY = 3'd0;
    localparam logic [2:0] COLOR_FIRST = 3'd1;
    localparam logic [2:0] COLOR_LAST  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INPUT,
        ST_CHECK,
        ST_WIN,
        ST_LOSE
    } state_t;

    // True when every slot of a 4-slot code holds a colour (no empty slot).
    function automatic logic codeValid(input logic [ROW_BITS-1:0] code);
        logic ok;
        ok = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (code[c*SLOT_BITS +: SLOT_BITS] == COLOR_EMPTY) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/mastermind_score.sv
// Purely combinational Mastermind scorer: black = exact position matches,
// white = colour matches in the wrong position.
module mastermind_score
    import mastermind_pkg::*;
(
    input  logic [ROW_BITS-1:0] guess_i,
    input  logic [ROW_BITS-1:0] secret_i,
    output logic [2:0]          black_o,
    output logic [2:0]          white_o
);

    logic [2:0] blackCnt;
    logic [2:0] matchCnt;
    logic [2:0] guessCnt;
    logic [2:0] secretCnt;

    // Count exact hits, then total colour overlap via per-colour minimum counts.
    always_comb begin
        blackCnt  = '0;
        matchCnt  = '0;
        guessCnt  = '0;
        secretCnt = '0;
        for (int c = 0; c < COLS; c++) begin
            if (guess_i[c*SLOT_BITS +: SLOT_BITS] == secret_i[c*SLOT_BITS +: SLOT_BITS]) begin
                blackCnt = blackCnt + 3'd1;
            end
        end
        for (int k = 1; k <= 6; k++) begin
            guessCnt  = '0;
            secretCnt = '0;
            for (int c = 0; c < COLS; c++) begin
                if (guess_i[c*SLOT_BITS +: SLOT_BITS] == 3'(k)) begin
                    guessCnt = guessCnt + 3'd1;
                end
                if (secret_i[c*SLOT_BITS +: SLOT_BITS] == 3'(k)) begin
                    secretCnt = secretCnt + 3'd1;
                end
            end
            matchCnt = matchCnt + ((guessCnt < secretCnt) ? guessCnt : secretCnt);
        end
        black_o = blackCnt;
        white_o = matchCnt - blackCnt;
    end

endmodule

// File: rtl/mastermind_game_ctrl.sv
// Mastermind game controller: cursor/colour editing of the active guess row,
// one-cycle scoring in CHECK, win/lose detection after six rows.
// Define MASTERMIND_FEEDBACK_EN to drive per-row black/white feedback;
// without it feedback_flat stays zero and only the all-black test is used.
module mastermind_game_ctrl
    import mastermind_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] secret_code,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_color,
    input  logic        btn_place,
    input  logic        btn_submit,
    output logic [71:0] matrix_flat,
    output logic [2:0]  guess_num,
    output logic [1:0]  cursor_index,
    output logic [2:0]  current_color,
    output logic        q_Input,
    output logic [35:0] feedback_flat,
    output logic        win,
    output logic        lose
);

    state_t      state_q, state_d;
    logic [71:0] matrix_q, matrix_d;
    logic [35:0] feedback_q, feedback_d;
    logic [11:0] secret_q, secret_d;
    logic [2:0]  guess_q, guess_d;
    logic [1:0]  cursor_q, cursor_d;
    logic [2:0]  color_q, color_d;
    logic        input_q, win_q, lose_q;

    logic [6:0]  rowBase;
    logic [6:0]  slotBase;
    logic [11:0] activeRow;
    logic        rowFull;
    logic [2:0]  black;
    logic [2:0]  white;
    logic        allBlack;

    assign rowBase   = {4'd0, guess_q} * 7'd12;
    assign slotBase  = rowBase + ({5'd0, cursor_q} * 7'd3);
    assign activeRow = matrix_q[rowBase +: ROW_BITS];
    assign rowFull   = codeValid(activeRow);

    mastermind_score u_score (
        .guess_i  (activeRow),
        .secret_i (secret_q),
        .black_o  (black),
        .white_o  (white)
    );

    assign allBlack = (black == 3'd4);

`ifdef MASTERMIND_FEEDBACK_EN
    logic [5:0] fbBase;
    assign fbBase = {3'd0, guess_q} * 6'd6;
`else
    logic unusedWhite;
    assign unusedWhite = ^white;
`endif

    // Next-state and datapath update: a valid start overrides everything,
    // otherwise the current state decides which button (if any) takes effect.
    always_comb begin
        state_d    = state_q;
        matrix_d   = matrix_q;
        feedback_d = feedback_q;
        secret_d   = secret_q;
        guess_d    = guess_q;
        cursor_d   = cursor_q;
        color_d    = color_q;
        if (start && codeValid(secret_code)) begin
            state_d    = ST_INPUT;
            matrix_d   = '0;
            feedback_d = '0;
            secret_d   = secret_code;
            guess_d    = '0;
            cursor_d   = '0;
            color_d    = COLOR_FIRST;
        end else begin
            case (state_q)
                ST_INPUT: begin
                    if (btn_submit) begin
                        if (rowFull) begin
                            state_d = ST_CHECK;
                        end
                    end else if (btn_place) begin
                        matrix_d[slotBase +: SLOT_BITS] = color_q;
                    end else if (btn_color) begin
                        color_d = (color_q == COLOR_LAST) ? COLOR_FIRST : color_q + 3'd1;
                    end else if (btn_left && !btn_right) begin
                        cursor_d = cursor_q - 2'd1;
                    end else if (btn_right && !btn_left) begin
                        cursor_d = cursor_q + 2'd1;
                    end
                end
                ST_CHECK: begin
`ifdef MASTERMIND_FEEDBACK_EN
                    feedback_d[fbBase +: FB_BITS] = {black, white};
`endif
                    if (allBlack) begin
                        state_d = ST_WIN;
                    end else if (guess_q == 3'(ROWS - 1)) begin
                        state_d = ST_LOSE;
                    end else begin
                        guess_d  = guess_q + 3'd1;
                        cursor_d = '0;
                        color_d  = COLOR_FIRST;
                        state_d  = ST_INPUT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State, board and status flags; reset wins over any pending score.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            matrix_q   <= '0;
            feedback_q <= '0;
            secret_q   <= '0;
            guess_q    <= '0;
            cursor_q   <= '0;
            color_q    <= COLOR_FIRST;
            input_q    <= 1'b0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            matrix_q   <= matrix_d;
            feedback_q <= feedback_d;
            secret_q   <= secret_d;
            guess_q    <= guess_d;
            cursor_q   <= cursor_d;
            color_q    <= color_d;
            input_q    <= (state_d == ST_INPUT);
            win_q      <= (state_d == ST_WIN);
            lose_q     <= (state_d == ST_LOSE);
        end
    end

    assign matrix_flat   = matrix_q;
    assign feedback_flat = feedback_q;
    assign guess_num     = guess_q;
    assign cursor_index  = cursor_q;
    assign current_color = color_q;
    assign q_Input       = input_q;
    assign win           = win_q;
    assign lose          = lose_q;

endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// Self-checking bench for mastermind_game_ctrl: directed vector table,
// hand-written game sequences and randomized play against a game model.
// Honours MASTERMIND_FEEDBACK_EN for expected feedback values.
module tb_mastermind_game_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] secret_code = '0;
    logic        btn_left = 1'b0, btn_right = 1'b0, btn_color = 1'b0;
    logic        btn_place = 1'b0, btn_submit = 1'b0;
    logic [71:0] matrix_flat;
    logic [2:0]  guess_num;
    logic [1:0]  cursor_index;
    logic [2:0]  current_color;
    logic        q_Input;
    logic [35:0] feedback_flat;
    logic        win, lose;

    mastermind_game_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .secret_code   (secret_code),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_color     (btn_color),
        .btn_place     (btn_place),
        .btn_submit    (btn_submit),
        .matrix_flat   (matrix_flat),
        .guess_num     (guess_num),
        .cursor_index  (cursor_index),
        .current_color (current_color),
        .q_Input       (q_Input),
        .feedback_flat (feedback_flat),
        .win           (win),
        .lose          (lose)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_SUB  = 5'b10000;
    localparam logic [4:0] B_PL   = 5'b01000;
    localparam logic [4:0] B_CO   = 5'b00100;
    localparam logic [4:0] B_LE   = 5'b00010;
    localparam logic [4:0] B_RI   = 5'b00001;

    localparam int MS_IDLE = 0, MS_INPUT = 1, MS_CHECK = 2, MS_WIN = 3, MS_LOSE = 4;

    int checks = 0;
    int failures = 0;

    // Behavioural game model
    int mState;
    int mBoard[6][4];
    int mSecret[4];
    int mFbB[6];
    int mFbW[6];
    int mGuess, mCursor, mColor;

    function automatic bit codeOk(input logic [11:0] code);
        for (int c = 0; c < 4; c++) if (code[c*3 +: 3] == 3'd0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic modelClear();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 4; c++) mBoard[r][c] = 0;
            mFbB[r] = 0;
            mFbW[r] = 0;
        end
        mGuess = 0;
        mCursor = 0;
        mColor = 1;
    endtask

    task automatic modelScore(output int b, output int w);
        int total;
        int gc, sc;
        b = 0;
        total = 0;
        for (int c = 0; c < 4; c++) if (mBoard[mGuess][c] == mSecret[c]) b++;
        for (int k = 1; k <= 6; k++) begin
            gc = 0;
            sc = 0;
            for (int c = 0; c < 4; c++) begin
                if (mBoard[mGuess][c] == k) gc++;
                if (mSecret[c] == k) sc++;
            end
            total += (gc < sc) ? gc : sc;
        end
        w = total - b;
    endtask

    task automatic modelStep(input bit rst, input bit st, input logic [11:0] sec, input logic [4:0] btn);
        int b, w;
        bit full;
        if (rst) begin
            modelClear();
            for (int c = 0; c < 4; c++) mSecret[c] = 0;
            mState = MS_IDLE;
        end else if (st && codeOk(sec)) begin
            modelClear();
            for (int c = 0; c < 4; c++) mSecret[c] = int'(sec[c*3 +: 3]);
            mState = MS_INPUT;
        end else if (mState == MS_INPUT) begin
            if (btn[4]) begin
                full = 1'b1;
                for (int c = 0; c < 4; c++) if (mBoard[mGuess][c] == 0) full = 1'b0;
                if (full) mState = MS_CHECK;
            end else if (btn[3]) begin
                mBoard[mGuess][mCursor] = mColor;
            end else if (btn[2]) begin
                mColor = (mColor % 6) + 1;
            end else if (btn[1] && !btn[0]) begin
                mCursor = (mCursor + 3) % 4;
            end else if (btn[0] && !btn[1]) begin
                mCursor = (mCursor + 1) % 4;
            end
        end else if (mState == MS_CHECK) begin
            modelScore(b, w);
            mFbB[mGuess] = b;
            mFbW[mGuess] = w;
            if (b == 4) mState = MS_WIN;
            else if (mGuess == 5) mState = MS_LOSE;
            else begin
                mGuess++;
                mCursor = 0;
                mColor = 1;
                mState = MS_INPUT;
            end
        end
    endtask

    function automatic logic [71:0] expMatrix();
        logic [71:0] m;
        m = '0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 4; c++) m[r*12 + c*3 +: 3] = 3'(mBoard[r][c]);
        return m;
    endfunction

    function automatic logic [35:0] expFeedback();
        logic [35:0] f;
        f = '0;
`ifdef MASTERMIND_FEEDBACK_EN
        for (int r = 0; r < 6; r++) f[r*6 +: 6] = {3'(mFbB[r]), 3'(mFbW[r])};
`endif
        return f;
    endfunction

    task automatic checkField(input string name, input logic [71:0] actual, input logic [71:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkField({tag, ".matrix"}, matrix_flat, expMatrix());
        checkField({tag, ".feedback"}, 72'(feedback_flat), 72'(expFeedback()));
        checkField({tag, ".guess"}, 72'(guess_num), 72'(mGuess));
        checkField({tag, ".cursor"}, 72'(cursor_index), 72'(mCursor));
        checkField({tag, ".color"}, 72'(current_color), 72'(mColor));
        checkField({tag, ".qInput"}, 72'(q_Input), 72'(mState == MS_INPUT));
        checkField({tag, ".win"}, 72'(win), 72'(mState == MS_WIN));
        checkField({tag, ".lose"}, 72'(lose), 72'(mState == MS_LOSE));
    endtask

    task automatic applyStimulus(input bit rst, input bit st, input logic [11:0] sec, input logic [4:0] btn);
        reset = rst;
        start = st;
        secret_code = sec;
        {btn_submit, btn_place, btn_color, btn_left, btn_right} = btn;
        @(posedge clk);
        modelStep(rst, st, sec, btn);
        #1;
        reset = 1'b0;
        start = 1'b0;
        {btn_submit, btn_place, btn_color, btn_left, btn_right} = B_NONE;
    endtask

    task automatic step(input logic [4:0] btn, input string tag);
        applyStimulus(1'b0, 1'b0, secret_code, btn);
        checkOutput(tag);
    endtask

    task automatic startGame(input logic [11:0] sec, input string tag);
        applyStimulus(1'b0, 1'b1, sec, B_NONE);
        checkOutput(tag);
    endtask

    task automatic placeRow(input int a, input int b, input int c, input int d);
        int want[4];
        want = '{a, b, c, d};
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 6 && mColor != want[s]; k++) step(B_CO, "fill.color");
            step(B_PL, "fill.place");
            step(B_RI, "fill.move");
        end
    endtask

    typedef struct {
        bit          rst;
        bit          st;
        logic [11:0] sec;
        logic [4:0]  btn;
        int          eGuess;
        int          eCursor;
        int          eColor;
        bit          eQ;
    } vec_t;

    vec_t vecs[16];
    logic [71:0] savedMatrix;
    logic [4:0]  rb;
    logic [11:0] rs;
    int          rr;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 12'h000, B_NONE,      0, 0, 1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 12'h0D1, B_NONE,      0, 0, 1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 12'h0D1, B_CO,        0, 0, 1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 12'h29C, B_NONE,      0, 0, 1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 12'h29C, B_CO,        0, 0, 2, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 12'h29C, B_CO,        0, 0, 3, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 12'h29C, B_CO,        0, 0, 4, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 12'h29C, B_CO,        0, 0, 5, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 12'h29C, B_CO,        0, 0, 6, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 12'h29C, B_CO,        0, 0, 1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 12'h29C, B_LE,        0, 3, 1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 12'h29C, B_RI,        0, 0, 1, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 12'h29C, B_LE | B_RI, 0, 0, 1, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 12'h29C, B_RI | B_CO, 0, 0, 2, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 12'h29C, B_PL | B_CO, 0, 0, 2, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 12'h29C, B_SUB,       0, 0, 2, 1'b1};

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].st, vecs[i].sec, vecs[i].btn);
            checkOutput($sformatf("vec%0d", i));
            checkField($sformatf("vec%0d.tguess", i), 72'(guess_num), 72'(vecs[i].eGuess));
            checkField($sformatf("vec%0d.tcursor", i), 72'(cursor_index), 72'(vecs[i].eCursor));
            checkField($sformatf("vec%0d.tcolor", i), 72'(current_color), 72'(vecs[i].eColor));
            checkField($sformatf("vec%0d.tq", i), 72'(q_Input), 72'(vecs[i].eQ));
        end
        checkField("vec14.slot0", 72'(matrix_flat[2:0]), 72'd2);

        // Win: secret {1,2,3,4}, same guess
        startGame({3'd4, 3'd3, 3'd2, 3'd1}, "win.start");
        placeRow(1, 2, 3, 4);
        step(B_SUB, "win.submit");
        checkField("win.inCheck.q", 72'(q_Input), 72'd0);
        checkField("win.inCheck.win", 72'(win), 72'd0);
        step(B_NONE, "win.resolve");
        checkField("win.flag", 72'(win), 72'd1);
`ifdef MASTERMIND_FEEDBACK_EN
        checkField("win.fb0", 72'(feedback_flat[5:0]), 72'(6'b100_000));
`else
        checkField("win.fb0", 72'(feedback_flat), 72'd0);
`endif
        step(B_PL | B_CO, "win.ignored");

        // Scoring: secret {1,1,2,3}, guess {1,2,1,4}
        startGame({3'd3, 3'd2, 3'd1, 3'd1}, "score.start");
        placeRow(1, 2, 1, 4);
        step(B_SUB, "score.submit");
        step(B_NONE, "score.resolve");
`ifdef MASTERMIND_FEEDBACK_EN
        checkField("score.fb0", 72'(feedback_flat[5:0]), 72'({3'd1, 3'd2}));
`else
        checkField("score.fb0", 72'(feedback_flat), 72'd0);
`endif
        checkField("score.guess", 72'(guess_num), 72'd1);
        checkField("score.cursor", 72'(cursor_index), 72'd0);
        checkField("score.q", 72'(q_Input), 72'd1);

        // Lose: empty-slot submit ignored, then six non-winning rows
        startGame(12'h249, "lose.start");
        step(B_SUB, "lose.emptySubmit");
        checkField("lose.emptySubmit.q", 72'(q_Input), 72'd1);
        for (int r = 0; r < 6; r++) begin
            placeRow(2, 2, 2, 2);
            step(B_SUB, "lose.submit");
            step(B_NONE, "lose.resolve");
        end
        checkField("lose.flag", 72'(lose), 72'd1);
        checkField("lose.guess", 72'(guess_num), 72'd5);
        savedMatrix = expMatrix();
        step(B_PL, "lose.place");
        checkField("lose.matrixKept", matrix_flat, savedMatrix);

        // Reset in the middle of CHECK
        startGame({3'd4, 3'd3, 3'd2, 3'd1}, "rst.start");
        placeRow(1, 2, 3, 4);
        step(B_SUB, "rst.submit");
        applyStimulus(1'b1, 1'b0, secret_code, B_NONE);
        checkOutput("rst.midCheck");
        checkField("rst.matrix", matrix_flat, 72'd0);
        checkField("rst.fb", 72'(feedback_flat), 72'd0);
        checkField("rst.color", 72'(current_color), 72'd1);
        checkField("rst.win", 72'(win), 72'd0);
        step(B_NONE, "rst.after");
        checkField("rst.after.q", 72'(q_Input), 72'd0);

        // Randomized play
        startGame(12'h249, "rand.start");
        for (int i = 0; i < 800; i++) begin
            rr = $urandom_range(0, 99);
            if (rr < 1) begin
                applyStimulus(1'b1, 1'b0, secret_code, B_NONE);
            end else if (rr < 4) begin
                for (int c = 0; c < 4; c++) rs[c*3 +: 3] = 3'($urandom_range(0, 6));
                applyStimulus(1'b0, 1'b1, rs, 5'($urandom));
            end else begin
                rr = $urandom_range(0, 99);
                if (rr < 10) rb = B_SUB;
                else if (rr < 45) rb = B_PL;
                else if (rr < 65) rb = B_CO;
                else if (rr < 75) rb = B_LE;
                else if (rr < 85) rb = B_RI;
                else rb = 5'($urandom);
                applyStimulus(1'b0, 1'b0, secret_code, rb);
            end
            checkOutput($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
